// File: rtl/keypad_scan_fifo_if.sv
// Event stream from the keypad scanner: {release_flag, key_code} with valid/ready handshake.
interface keypad_scan_fifo_if #(
    parameter int KW = 4
);
    logic [KW:0] ev_data;
    logic        ev_valid;
    logic        ev_ready;

    modport master (output ev_data, output ev_valid, input ev_ready);
    modport slave  (input ev_data, input ev_valid, output ev_ready);
endinterface

// File: rtl/keypad_scan_fifo.sv
// Matrix keypad scanner: column drive, frame capture, debounce, press/release events into a FIFO.
module keypad_scan_fifo #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int DEBOUNCE   = 3,
    parameter int FIFO_DEPTH = 4,
    localparam int KW        = $clog2(ROWS * COLS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ROWS-1:0]     row,
    output logic [COLS-1:0]     col,
    keypad_scan_fifo_if.master  ev,
    output logic                key_held,
    output logic [KW-1:0]       held_code,
    output logic                overflow
);
    localparam int NK = ROWS * COLS;
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {CL_NONE, CL_SINGLE, CL_MULTI} cls_t;

    logic [ROWS-1:0] r_row_s1, r_row_s2;
    logic [DW-1:0]   r_div;
    logic [CW-1:0]   r_idx;
    logic [COLS-1:0] r_col;
    logic [NK-1:0]   r_frame;
    logic            r_frame_done;

    logic            w_div_end;
    logic [CW-1:0]   w_idx_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row_s1 <= '1;
            r_row_s2 <= '1;
        end else begin
            r_row_s1 <= row;
            r_row_s2 <= r_row_s1;
        end
    end

    assign w_div_end  = (r_div == DW'(SCAN_DIV - 1));
    assign w_idx_next = (r_idx == CW'(COLS - 1)) ? '0 : r_idx + CW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div        <= '0;
            r_idx        <= '0;
            r_col        <= ~COLS'(1);
            r_frame      <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_div_end) begin
                r_div <= '0;
                for (int unsigned c = 0; c < COLS; c++) begin
                    if (r_idx == CW'(c)) r_frame[c*ROWS +: ROWS] <= r_row_s2;
                end
                r_idx        <= w_idx_next;
                r_col        <= ~(COLS'(1) << w_idx_next);
                r_frame_done <= (r_idx == CW'(COLS - 1));
            end else begin
                r_div <= r_div + DW'(1);
            end
        end
    end

    assign col = r_col;

    // Frame bit index is c*ROWS + r, which is directly the key code.
    cls_t          w_cls;
    logic [KW-1:0] w_code;

    always_comb begin
        w_cls  = CL_NONE;
        w_code = '0;
        for (int unsigned i = 0; i < NK; i++) begin
            if (!r_frame[i]) begin
                if (w_cls == CL_NONE) begin
                    w_cls  = CL_SINGLE;
                    w_code = KW'(i);
                end else begin
                    w_cls = CL_MULTI;
                end
            end
        end
        if (w_cls != CL_SINGLE) w_code = '0;
    end

    cls_t          r_cand_cls, w_cand_cls_next;
    logic [KW-1:0] r_cand_code, w_cand_code_next;
    logic [BW-1:0] r_cnt, w_cnt_next;
    cls_t          r_stable_cls, w_stable_cls_next;
    logic [KW-1:0] r_stable_code, w_stable_code_next;
    logic          w_push;
    logic [KW:0]   w_push_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cand_cls    <= CL_NONE;
            r_cand_code   <= '0;
            r_cnt         <= '0;
            r_stable_cls  <= CL_NONE;
            r_stable_code <= '0;
        end else begin
            r_cand_cls    <= w_cand_cls_next;
            r_cand_code   <= w_cand_code_next;
            r_cnt         <= w_cnt_next;
            r_stable_cls  <= w_stable_cls_next;
            r_stable_code <= w_stable_code_next;
        end
    end

    // Stable update is judged on the post-update candidate/counter so it lands in the same cycle.
    always_comb begin
        w_cand_cls_next    = r_cand_cls;
        w_cand_code_next   = r_cand_code;
        w_cnt_next         = r_cnt;
        w_stable_cls_next  = r_stable_cls;
        w_stable_code_next = r_stable_code;
        w_push             = 1'b0;
        w_push_data        = '0;
        if (r_frame_done) begin
            if (w_cls == r_cand_cls && w_code == r_cand_code) begin
                if (r_cnt != BW'(DEBOUNCE)) w_cnt_next = r_cnt + BW'(1);
            end else begin
                w_cand_cls_next  = w_cls;
                w_cand_code_next = w_code;
                w_cnt_next       = BW'(1);
            end
            if (w_cnt_next == BW'(DEBOUNCE) &&
                (w_cand_cls_next != r_stable_cls || w_cand_code_next != r_stable_code)) begin
                w_stable_cls_next  = w_cand_cls_next;
                w_stable_code_next = w_cand_code_next;
                if (r_stable_cls == CL_SINGLE) begin
                    w_push      = 1'b1;
                    w_push_data = {1'b1, r_stable_code};
                end else if (r_stable_cls == CL_NONE && w_cand_cls_next == CL_SINGLE) begin
                    w_push      = 1'b1;
                    w_push_data = {1'b0, w_cand_code_next};
                end
            end
        end
    end

    logic          r_key_held;
    logic [KW-1:0] r_held_code;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_held  <= 1'b0;
            r_held_code <= '0;
        end else begin
            r_key_held  <= (r_stable_cls == CL_SINGLE);
            r_held_code <= (r_stable_cls == CL_SINGLE) ? r_stable_code : '0;
        end
    end

    assign key_held  = r_key_held;
    assign held_code = r_held_code;

    logic [KW:0] r_mem [FIFO_DEPTH];
    logic [FW:0] r_wr, r_rd;
    logic        r_overflow;
    logic        w_empty, w_full, w_pop, w_push_ok;

    assign w_empty   = (r_wr == r_rd);
    assign w_full    = (r_wr[FW] != r_rd[FW]) && (r_wr[FW-1:0] == r_rd[FW-1:0]);
    assign w_pop     = !w_empty && ev.ev_ready;
    assign w_push_ok = w_push && (!w_full || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr       <= '0;
            r_rd       <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr[FW-1:0]] <= w_push_data;
                r_wr                <= r_wr + (FW+1)'(1);
            end
            if (w_pop) r_rd <= r_rd + (FW+1)'(1);
            if (w_push && !w_push_ok) r_overflow <= 1'b1;
        end
    end

    assign ev.ev_data  = r_mem[r_rd[FW-1:0]];
    assign ev.ev_valid = !w_empty;
    assign overflow    = r_overflow;
endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Directed bench for keypad_scan_fifo: table of key patterns plus overflow and mid-frame reset sequences.
module tb_keypad_scan_fifo;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int KW    = 4;
    localparam int FRAME = 32;

    localparam logic [15:0] K0  = 16'h0001;
    localparam logic [15:0] K5  = 16'h0020;
    localparam logic [15:0] K6  = 16'h0040;
    localparam logic [15:0] K9  = 16'h0200;
    localparam logic [15:0] K15 = 16'h8000;

    logic            clk = 1'b0;
    logic            rst;
    logic [ROWS-1:0] row;
    logic [COLS-1:0] col;
    logic            key_held;
    logic [KW-1:0]   held_code;
    logic            overflow;
    logic [15:0]     keys;

    keypad_scan_fifo_if #(.KW(KW)) ev_if ();

    keypad_scan_fifo #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(8), .DEBOUNCE(3), .FIFO_DEPTH(4)
    ) u_dut (
        .clk(clk), .rst(rst), .row(row), .col(col), .ev(ev_if),
        .key_held(key_held), .held_code(held_code), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Keypad model: pressed key (r,c) pulls row r low while column c is driven low.
    always_comb begin
        row = '1;
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++)
                if (keys[c*ROWS + r] && !col[c]) row[r] = 1'b0;
    end

    logic [4:0] evq[$];
    always @(negedge clk) if (ev_if.ev_valid && ev_if.ev_ready) evq.push_back(ev_if.ev_data);

    int n_err = 0;
    int n_chk = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [15:0] keys;
        int unsigned frames;
        logic        held;
        logic [3:0]  code;
        int unsigned nev;
        logic [4:0]  ev;
    } vec_t;

    vec_t       vt[19];
    logic [3:0] col_exp[4];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        int cnt;
        logic [3:0] prev;

        vt[0] = '{16'h0000, 2, 1'b0, 4'd0,  0, 5'b0_0000};
        vt[1] = '{K9,       6, 1'b1, 4'd9,  1, 5'b0_1001};
        vt[2] = '{16'h0000, 6, 1'b0, 4'd0,  1, 5'b1_1001};
        for (int i = 0; i < 5; i++) begin
            vt[3 + 2*i] = '{K9,       2, 1'b0, 4'd0, 0, 5'b0_0000};
            vt[4 + 2*i] = '{16'h0000, 1, 1'b0, 4'd0, 0, 5'b0_0000};
        end
        vt[13] = '{16'h0000, 6, 1'b0, 4'd0,  0, 5'b0_0000};
        vt[14] = '{K0 | K15, 6, 1'b0, 4'd0,  0, 5'b0_0000};
        vt[15] = '{K15,      6, 1'b1, 4'd15, 0, 5'b0_0000};
        vt[16] = '{16'h0000, 6, 1'b0, 4'd0,  1, 5'b1_1111};
        vt[17] = '{K15,      6, 1'b1, 4'd15, 1, 5'b0_1111};
        vt[18] = '{16'h0000, 6, 1'b0, 4'd0,  1, 5'b1_1111};
        col_exp[0] = 4'b1101;
        col_exp[1] = 4'b1011;
        col_exp[2] = 4'b0111;
        col_exp[3] = 4'b1110;

        rst = 1'b1;
        keys = '0;
        ev_if.ev_ready = 1'b1;
        tick(3);
        check("rst_col",       col, 4'b1110);
        check("rst_ev_valid",  ev_if.ev_valid, 0);
        check("rst_ev_data",   ev_if.ev_data, 0);
        check("rst_key_held",  key_held, 0);
        check("rst_held_code", held_code, 0);
        check("rst_overflow",  overflow, 0);
        rst = 1'b0;

        for (int s = 0; s < 4; s++) begin
            prev = col;
            cnt = 0;
            while (col == prev && cnt < 20) begin
                tick(1);
                cnt++;
            end
            check($sformatf("col_step%0d_period", s), cnt, 8);
            check($sformatf("col_step%0d_value", s), col, col_exp[s]);
        end

        for (int i = 0; i < 19; i++) begin
            base = evq.size();
            keys = vt[i].keys;
            tick(vt[i].frames * FRAME);
            check($sformatf("v%0d_key_held", i), key_held, vt[i].held);
            check($sformatf("v%0d_held_code", i), held_code, vt[i].code);
            check($sformatf("v%0d_num_events", i), evq.size() - base, vt[i].nev);
            if (evq.size() > base) check($sformatf("v%0d_ev_data", i), evq[base], vt[i].ev);
            check($sformatf("v%0d_overflow", i), overflow, 0);
        end

        // Six events with the consumer stalled: first four kept, the rest dropped.
        base = evq.size();
        ev_if.ev_ready = 1'b0;
        keys = K5;  tick(6 * FRAME);
        keys = '0;  tick(6 * FRAME);
        keys = K6;  tick(6 * FRAME);
        keys = '0;  tick(6 * FRAME);
        keys = K9;  tick(6 * FRAME);
        keys = '0;  tick(6 * FRAME);
        check("ovf_no_pop",   evq.size() - base, 0);
        check("ovf_valid",    ev_if.ev_valid, 1);
        check("ovf_head",     ev_if.ev_data, 5'b0_0101);
        check("ovf_flag",     overflow, 1);
        tick(5);
        check("ovf_head_hold", ev_if.ev_data, 5'b0_0101);
        ev_if.ev_ready = 1'b1;
        tick(12);
        check("drain_count", evq.size() - base, 4);
        if (evq.size() >= base + 4) begin
            check("drain_ev0", evq[base],     5'b0_0101);
            check("drain_ev1", evq[base + 1], 5'b1_0101);
            check("drain_ev2", evq[base + 2], 5'b0_0110);
            check("drain_ev3", evq[base + 3], 5'b1_0110);
        end
        check("drain_valid", ev_if.ev_valid, 0);
        check("ovf_sticky",  overflow, 1);

        // Reset mid-frame while a key is held: the press must be reported again.
        keys = K9;
        tick(6 * FRAME + 11);
        check("pre_rst_held", key_held, 1);
        rst = 1'b1;
        tick(2);
        check("midrst_overflow", overflow, 0);
        check("midrst_col",      col, 4'b1110);
        check("midrst_key_held", key_held, 0);
        rst = 1'b0;
        base = evq.size();
        tick(6 * FRAME);
        check("redetect_count", evq.size() - base, 1);
        if (evq.size() > base) check("redetect_ev", evq[base], 5'b0_1001);
        check("redetect_held", key_held, 1);
        check("redetect_code", held_code, 9);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
